// File: rtl/mod_n_count_ctrl_if.sv
// mod_n_count_ctrl_if: configuration handshake, run controls and status of the modulo-N sequencer
interface mod_n_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_last;
    logic [7:0]       cfg_passes;
    logic             start;
    logic             pause;
    logic             stop;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic [7:0]       pass_cnt;
    logic             busy;
    logic             done;

    modport master (
        output cfg_valid, cfg_last, cfg_passes, start, pause, stop,
        input  cfg_ready, q, tc, pass_cnt, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_last, cfg_passes, start, pause, stop,
        output cfg_ready, q, tc, pass_cnt, busy, done
    );
endinterface

// File: rtl/mod_n_count_ctrl.sv
// mod_n_count_ctrl: runtime-configurable modulo-N counter with pass counting, pause, stop and done
module mod_n_count_ctrl #(
    parameter int WIDTH        = 4,
    parameter int DEFAULT_LAST = 13
) (
    input logic              clk,
    input logic              clr,
    mod_n_count_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARMED, RUN, PAUSED, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] last;
    logic [7:0]       passes;
    logic [7:0]       pass_cnt;
    logic             done;
    logic             ready;
    logic             active;
    logic             handshake;
    logic             wrap;
    logic             finish;

    assign ready     = state == IDLE || state == ARMED || state == DONE;
    assign active    = state == ARMED || state == RUN || state == PAUSED;
    assign handshake = ready & bus.cfg_valid;
    assign wrap      = q == last;
    assign finish    = passes != 8'd0 && pass_cnt + 8'd1 == passes;

    assign bus.cfg_ready = ready;
    assign bus.q         = q;
    assign bus.tc        = state == RUN && !bus.pause && wrap;
    assign bus.pass_cnt  = pass_cnt;
    assign bus.busy      = state == RUN || state == PAUSED;
    assign bus.done      = done;

    // sequencing: stop beats a handshake/start, which beats pause, which beats counting
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            q        <= '0;
            last     <= WIDTH'(DEFAULT_LAST);
            passes   <= 8'd0;
            pass_cnt <= 8'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.stop && active) begin
                state    <= IDLE;
                q        <= '0;
                pass_cnt <= 8'd0;
            end else if (handshake) begin
                last     <= bus.cfg_last;
                passes   <= bus.cfg_passes;
                q        <= '0;
                pass_cnt <= 8'd0;
                state    <= bus.start ? RUN : ARMED;
            end else if (ready && bus.start) begin
                state    <= RUN;
                q        <= '0;
                pass_cnt <= 8'd0;
            end else if (state == RUN) begin
                if (bus.pause) begin
                    state <= PAUSED;
                end else if (wrap) begin
                    q        <= '0;
                    pass_cnt <= pass_cnt + 8'd1;
                    if (finish) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end else begin
                    q <= q + 1'b1;
                end
            end else if (state == PAUSED && !bus.pause) begin
                state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_mod_n_count_ctrl.sv
// tb_mod_n_count_ctrl: directed test-plan scenarios plus random stimulus against a tick-based model
module tb_mod_n_count_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    mod_n_count_ctrl_if #(.WIDTH(W)) bus();
    mod_n_count_ctrl #(.WIDTH(W), .DEFAULT_LAST(13)) dut (.clk(clk), .clr(clr), .bus(bus));

    typedef enum int {M_IDLE, M_ARMED, M_RUN, M_PAUSED, M_DONE} mode_t;

    int    total = 0;
    int    bad = 0;
    mode_t mode = M_IDLE;
    int    ticks = 0;
    int    m_last = 13;
    int    m_passes = 0;
    bit    m_done = 1'b0;
    bit    known = 1'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // the run is a count of advancing ticks; q and pass_cnt are its remainder and quotient
    task automatic check_outputs();
        int mq;
        int mp;
        mq = ticks % (m_last + 1);
        mp = (ticks / (m_last + 1)) % 256;
        chk("q", 32'(bus.q), 32'(mq));
        chk("pass_cnt", 32'(bus.pass_cnt), 32'(mp));
        chk("tc", 32'(bus.tc), 32'(mode == M_RUN && !bus.pause && mq == m_last));
        chk("busy", 32'(bus.busy), 32'(mode == M_RUN || mode == M_PAUSED));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(mode == M_IDLE || mode == M_ARMED || mode == M_DONE));
        chk("done", 32'(bus.done), 32'(m_done));
    endtask

    task automatic model_edge(bit c, bit sp, bit cv, int cl, int cp, bit st, bit pa);
        bit rdy;
        rdy = mode == M_IDLE || mode == M_ARMED || mode == M_DONE;
        if (c) begin
            mode = M_IDLE; ticks = 0; m_last = 13; m_passes = 0; m_done = 1'b0; known = 1'b1;
        end else begin
            m_done = 1'b0;
            if (sp && (mode == M_ARMED || mode == M_RUN || mode == M_PAUSED)) begin
                mode = M_IDLE; ticks = 0;
            end else if (rdy && cv) begin
                m_last = cl; m_passes = cp; ticks = 0;
                mode = st ? M_RUN : M_ARMED;
            end else if (rdy && st) begin
                mode = M_RUN; ticks = 0;
            end else if (mode == M_RUN) begin
                if (pa) mode = M_PAUSED;
                else begin
                    ticks++;
                    if (m_passes != 0 && ticks == m_passes * (m_last + 1)) begin
                        mode = M_DONE; m_done = 1'b1;
                    end
                end
            end else if (mode == M_PAUSED && !pa) begin
                mode = M_RUN;
            end
        end
    endtask

    task automatic step(bit c, bit sp, bit cv, int cl, int cp, bit st, bit pa);
        clr = c;
        bus.stop = sp;
        bus.cfg_valid = cv;
        bus.cfg_last = W'(cl);
        bus.cfg_passes = 8'(cp);
        bus.start = st;
        bus.pause = pa;
        @(negedge clk);
        if (known) check_outputs();
        @(posedge clk);
        model_edge(c, sp, cv, cl, cp, st, pa);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(30);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4, 2, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(12);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
        idle(15);
        step(0, 0, 1, 2, 1, 1, 0);
        idle(6);
        step(0, 0, 1, 4, 0, 1, 0);
        idle(3);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(8);
        step(0, 0, 1, 13, 0, 1, 0);
        idle(9);
        step(1, 1, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(3);
        step(0, 0, 1, 5, 1, 0, 0);
        idle(16);
        step(0, 0, 1, 0, 3, 1, 0);
        idle(5);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 11) == 0,
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 7) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
